// File: rtl/diff_drive_pwm.sv
// Differential-drive output stage: mixes a signed control word with a base speed,
// clamps and slew-limits each wheel, and emits sign/magnitude PWM with direction bits.
module diff_drive_pwm #(
   parameter int CONTROL_WIDTH = 16,
   parameter int DUTY_WIDTH    = 8,
   parameter int SLEW_STEP     = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clk_en,
   input  logic                            en,
   input  logic signed [CONTROL_WIDTH-1:0] control_in,
   input  logic                            control_valid,
   input  logic        [DUTY_WIDTH-1:0]    base_speed,
   output logic                            pwm_l,
   output logic                            pwm_r,
   output logic                            dir_l,
   output logic                            dir_r,
   output logic        [DUTY_WIDTH-1:0]    duty_l,
   output logic        [DUTY_WIDTH-1:0]    duty_r,
   output logic                            period_start
);

   localparam int MW = CONTROL_WIDTH + 2;
   localparam int AW = DUTY_WIDTH + 1;
   localparam logic        [DUTY_WIDTH-1:0] DMAX   = {DUTY_WIDTH{1'b1}};
   localparam logic signed [MW-1:0]         DMAX_M = $signed({{(MW-DUTY_WIDTH){1'b0}}, DMAX});
   localparam logic signed [AW:0]           STEP_S = (AW+1)'(SLEW_STEP);

   function automatic logic signed [AW-1:0] clamp_f(input logic signed [MW-1:0] v);
      logic signed [AW-1:0] r;
      if (v > DMAX_M) begin
         r = $signed({1'b0, DMAX});
      end else if (v < -DMAX_M) begin
         r = -$signed({1'b0, DMAX});
      end else begin
         r = v[AW-1:0];
      end
      return r;
   endfunction

   // Moves the applied duty toward the target by at most SLEW_STEP, so a sign
   // change can only happen once the wheel is within one step of zero.
   function automatic logic signed [AW-1:0] slew_f(input logic signed [AW-1:0] app,
                                                   input logic signed [AW-1:0] tgt);
      logic signed [AW:0]   diff;
      logic signed [AW-1:0] r;
      diff = {tgt[AW-1], tgt} - {app[AW-1], app};
      if (SLEW_STEP == 0) begin
         r = tgt;
      end else if (diff > STEP_S) begin
         r = app + STEP_S[AW-1:0];
      end else if (diff < -STEP_S) begin
         r = app - STEP_S[AW-1:0];
      end else begin
         r = tgt;
      end
      return r;
   endfunction

   function automatic logic [DUTY_WIDTH-1:0] mag_f(input logic signed [AW-1:0] a);
      return a[AW-1] ? DUTY_WIDTH'(-a) : DUTY_WIDTH'(a);
   endfunction

   logic signed [CONTROL_WIDTH-1:0] stage_r;
   logic        [DUTY_WIDTH-1:0]    cnt_r;
   logic signed [AW-1:0]            app_l_r, app_r_r;
   logic signed [MW-1:0]            base_m_s, stage_m_s, mix_l_s, mix_r_s;
   logic signed [AW-1:0]            app_l_nxt_s, app_r_nxt_s;
   logic                            boundary_s;

   assign boundary_s = clk_en & en & (cnt_r == DMAX);

   // Mix, clamp and slew for the next period boundary
   always_comb begin
      base_m_s    = $signed({{(MW-DUTY_WIDTH){1'b0}}, base_speed});
      stage_m_s   = $signed({{(MW-CONTROL_WIDTH){stage_r[CONTROL_WIDTH-1]}}, stage_r});
      mix_l_s     = base_m_s + stage_m_s;
      mix_r_s     = base_m_s - stage_m_s;
      app_l_nxt_s = slew_f(app_l_r, clamp_f(mix_l_s));
      app_r_nxt_s = slew_f(app_r_r, clamp_f(mix_r_s));
   end

   // Control staging register, loads regardless of enables
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_r <= '0;
      end else if (control_valid) begin
         stage_r <= control_in;
      end
   end

   // Period counter, applied duty, direction and PWM outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r        <= '0;
         app_l_r      <= '0;
         app_r_r      <= '0;
         duty_l       <= '0;
         duty_r       <= '0;
         dir_l        <= 1'b1;
         dir_r        <= 1'b1;
         pwm_l        <= 1'b0;
         pwm_r        <= 1'b0;
         period_start <= 1'b0;
      end else if (!en) begin
         cnt_r        <= '0;
         app_l_r      <= '0;
         app_r_r      <= '0;
         duty_l       <= '0;
         duty_r       <= '0;
         dir_l        <= 1'b1;
         dir_r        <= 1'b1;
         pwm_l        <= 1'b0;
         pwm_r        <= 1'b0;
         period_start <= 1'b0;
      end else begin
         if (clk_en) begin
            cnt_r <= cnt_r + DUTY_WIDTH'(1);
         end
         period_start <= boundary_s;
         if (boundary_s) begin
            app_l_r <= app_l_nxt_s;
            app_r_r <= app_r_nxt_s;
            duty_l  <= mag_f(app_l_nxt_s);
            duty_r  <= mag_f(app_r_nxt_s);
            dir_l   <= ~app_l_nxt_s[AW-1];
            dir_r   <= ~app_r_nxt_s[AW-1];
         end
         pwm_l <= (cnt_r < duty_l);
         pwm_r <= (cnt_r < duty_r);
      end
   end

endmodule
